// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bridge FSM states, access size codes and address helpers
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // kseg0/kseg1 live at 0x8000_0000-0xBFFF_FFFF and map onto the low 512 MB
    localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return vaddr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/addr_map.sv
// rtl/addr_map.sv - combinational virtual-to-physical data address translation
module addr_map
    import bus_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (is_kseg01(vaddr)) begin
            paddr = vaddr & KSEG_PHYS_MASK;
        end
    end

endmodule

// File: rtl/d_sram_bridge.sv
// rtl/d_sram_bridge.sv - M-stage load/store to SRAM-like bus bridge; DSRAM_ADDR_MAP_EN enables kseg0/1 translation
module d_sram_bridge
    import bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    bridge_state_t     state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_store;

    assign is_store = |wen_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        data_req  = 1'b0;
        mem_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_stall = mem_en & ~flush;
                if (mem_en && !flush) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wen_d   = mem_wen;
                    size_d  = mem_size;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // data_ok is never looked at here, so one coinciding with addr_ok is dropped
                data_req  = 1'b1;
                mem_stall = 1'b1;
                if (data_addr_ok) begin
                    state_d = flush ? ST_DRAIN : ST_DATA;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                mem_stall = ~data_data_ok;
                if (data_data_ok) begin
                    if (!is_store) begin
                        rdata_d = data_rdata;
                    end
                    state_d = longest_stall ? ST_HOLD : ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (!longest_stall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // the bus still owes one response; a new request must wait for it
                mem_stall = mem_en;
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_rdata  = rdata_q;
    assign data_wr    = is_store;
    assign data_size  = size_q;
    assign data_wdata = wdata_q;

`ifdef DSRAM_ADDR_MAP_EN
    addr_map u_addr_map (
        .vaddr (addr_q),
        .paddr (data_addr)
    );
`else
    assign data_addr = addr_q;
`endif

endmodule

// File: tb/tb_d_sram_bridge.sv
// tb/tb_d_sram_bridge.sv - directed self-checking bench for d_sram_bridge
module tb_d_sram_bridge;
    import bus_pkg::*;

`ifdef DSRAM_ADDR_MAP_EN
    localparam bit MAP_EN = 1'b1;
`else
    localparam bit MAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    d_sram_bridge #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_size      (mem_size),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .flush         (flush),
        .longest_stall (longest_stall),
        .mem_rdata     (mem_rdata),
        .mem_stall     (mem_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_paddr(input logic [31:0] va);
        if (MAP_EN && va[31:30] == 2'b10) return {3'b000, va[28:0]};
        return va;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start_access(input logic [3:0] wen, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_size  = sz;
        mem_addr  = a;
        mem_wdata = wd;
    endtask

    initial begin
        int stable;
        int hs0;
        rst = 1'b1; mem_en = 1'b0; mem_wen = 4'h0; mem_size = 2'd0;
        mem_addr = 32'h0; mem_wdata = 32'h0; flush = 1'b0; longest_stall = 1'b0;
        data_rdata = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        step(); step();
        rst = 1'b0;
        settle();
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("rst_req", 32'(data_req), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'h0);

        // zero-wait load word: stalled in IDLE and ADDR, released in DATA with data_ok
        start_access(4'h0, SIZE_WORD, 32'h0000_0010, 32'h0);
        settle();
        check_eq("ld_idle_stall", 32'(mem_stall), 32'd1);
        step();
        data_addr_ok = 1'b1;
        settle();
        check_eq("ld_req", 32'(data_req), 32'd1);
        check_eq("ld_addr", data_addr, 32'h0000_0010);
        check_eq("ld_wr", 32'(data_wr), 32'd0);
        check_eq("ld_size", 32'(data_size), 32'(SIZE_WORD));
        check_eq("ld_addr_stall", 32'(mem_stall), 32'd1);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        settle();
        check_eq("ld_data_stall", 32'(mem_stall), 32'd0);
        step();
        mem_en = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        check_eq("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
        check_eq("ld_state", 32'(dut.state_q), 32'(ST_IDLE));

        // store byte to kseg0
        start_access(4'b0010, SIZE_BYTE, 32'h8000_0004, 32'h5555_5555);
        step();
        data_addr_ok = 1'b1;
        settle();
        check_eq("st_addr", data_addr, exp_paddr(32'h8000_0004));
        check_eq("st_wr", 32'(data_wr), 32'd1);
        check_eq("st_size", 32'(data_size), 32'(SIZE_BYTE));
        check_eq("st_wdata", data_wdata, 32'h5555_5555);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD;
        step();
        mem_en = 1'b0; data_data_ok = 1'b0;
        settle();
        check_eq("st_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

        // addr_ok withheld for 5 cycles
        hs0 = hs_cnt;
        stable = 0;
        start_access(4'h0, SIZE_HALF, 32'hBFC0_0020, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            if (data_req === 1'b1 && data_addr === exp_paddr(32'hBFC0_0020) &&
                data_size === SIZE_HALF && mem_stall === 1'b1) stable++;
            step();
        end
        check_eq("wait_stable", 32'(stable), 32'd5);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        step();
        mem_en = 1'b0; data_data_ok = 1'b0;
        settle();
        check_eq("wait_one_xfer", 32'(hs_cnt - hs0), 32'd1);
        check_eq("wait_rdata", mem_rdata, 32'hCAFE_F00D);

        // flush in ADDR without addr_ok
        hs0 = hs_cnt;
        start_access(4'h0, SIZE_WORD, 32'h0000_0020, 32'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; mem_en = 1'b0;
        settle();
        check_eq("fla_req", 32'(data_req), 32'd0);
        check_eq("fla_state", 32'(dut.state_q), 32'(ST_IDLE));
        data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        step();
        data_data_ok = 1'b0;
        settle();
        check_eq("fla_rdata", mem_rdata, 32'hCAFE_F00D);
        check_eq("fla_no_hs", 32'(hs_cnt - hs0), 32'd0);

        // flush in DATA, response two cycles later is discarded
        start_access(4'h0, SIZE_WORD, 32'h0000_0030, 32'h0);
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; mem_en = 1'b0;
        settle();
        check_eq("fld_state", 32'(dut.state_q), 32'(ST_DRAIN));
        check_eq("fld_req", 32'(data_req), 32'd0);
        mem_en = 1'b1; mem_addr = 32'h0000_0040;
        settle();
        check_eq("fld_drain_stall", 32'(mem_stall), 32'd1);
        step();
        mem_en = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        step();
        data_data_ok = 1'b0;
        settle();
        check_eq("fld_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("fld_rdata", mem_rdata, 32'hCAFE_F00D);

        // data_ok under longest_stall goes to HOLD for 3 cycles
        start_access(4'h0, SIZE_WORD, 32'h0000_0040, 32'h0);
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hA5A5_0001;
        longest_stall = 1'b1;
        step();
        data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF;
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (dut.state_q === ST_HOLD && data_req === 1'b0 &&
                mem_rdata === 32'hA5A5_0001 && mem_stall === 1'b0) stable++;
            step();
        end
        check_eq("hold_cycles", 32'(stable), 32'd3);
        longest_stall = 1'b0;
        step();
        mem_en = 1'b0;
        settle();
        check_eq("hold_exit", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("hold_rdata", mem_rdata, 32'hA5A5_0001);

        // store flushed in its IDLE cycle never reaches the bus
        start_access(4'hF, SIZE_WORD, 32'h0000_0050, 32'h7777_7777);
        flush = 1'b1;
        settle();
        check_eq("stfl_stall", 32'(mem_stall), 32'd0);
        step();
        flush = 1'b0; mem_en = 1'b0;
        settle();
        check_eq("stfl_req", 32'(data_req), 32'd0);

        // reset in the middle of a transaction
        start_access(4'h0, SIZE_WORD, 32'h0000_0060, 32'h0);
        step();
        rst = 1'b1; mem_en = 1'b0;
        step();
        rst = 1'b0;
        settle();
        check_eq("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("mrst_req", 32'(data_req), 32'd0);
        check_eq("mrst_rdata", mem_rdata, 32'h0);
        check_eq("mrst_addr", data_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
